// File: rtl/turn_signal_scheduler.sv
// Turn-signal lamp sequencer: shares the left/right 3-lamp banks between LEFT,
// RIGHT and HAZARD requests, times each phase and counts completed sequences.
module turn_signal_scheduler #(
    parameter int STEP_DIV = 4
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       LEFT,
    input  logic       RIGHT,
    input  logic       HAZARD,
    output logic [2:0] L_SIGNAL,
    output logic [2:0] R_SIGNAL,
    output logic       ERROR,
    output logic [7:0] CYCLES
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_L1      = 4'd1;
    localparam logic [3:0] S_L2      = 4'd2;
    localparam logic [3:0] S_L3      = 4'd3;
    localparam logic [3:0] S_R1      = 4'd4;
    localparam logic [3:0] S_R2      = 4'd5;
    localparam logic [3:0] S_R3      = 4'd6;
    localparam logic [3:0] S_HAZ_ON  = 4'd7;
    localparam logic [3:0] S_HAZ_OFF = 4'd8;
    localparam logic [3:0] S_ERR     = 4'd9;

    localparam logic [23:0] TMR_LAST = 24'(STEP_DIV - 1);

    logic [3:0]  state_reg, state_next;
    logic [23:0] tmr_reg;
    logic [7:0]  cycles_reg;
    logic [3:0]  decision;
    logic        phase_end;
    logic        count_en;
    logic        timed;
    logic        left_only;
    logic        right_only;
    logic [1:0]  l_level;
    logic [1:0]  r_level;

    assign phase_end  = (tmr_reg == TMR_LAST);
    assign timed      = (state_reg != S_IDLE) && (state_reg != S_ERR);
    assign left_only  = LEFT && !RIGHT && !HAZARD;
    assign right_only = RIGHT && !LEFT && !HAZARD;

    always_comb begin
        if (HAZARD)
            decision = S_HAZ_ON;
        else if (LEFT && RIGHT)
            decision = S_ERR;
        else if (LEFT)
            decision = S_L1;
        else if (RIGHT)
            decision = S_R1;
        else
            decision = S_IDLE;
    end

    // Timed states only look at inputs on their last cycle.
    always_comb begin
        state_next = state_reg;
        count_en   = 1'b0;
        case (state_reg)
            S_IDLE:    state_next = decision;
            S_L1:      if (phase_end) state_next = left_only  ? S_L2 : decision;
            S_L2:      if (phase_end) state_next = left_only  ? S_L3 : decision;
            S_R1:      if (phase_end) state_next = right_only ? S_R2 : decision;
            S_R2:      if (phase_end) state_next = right_only ? S_R3 : decision;
            S_L3, S_R3: begin
                if (phase_end) begin
                    state_next = S_IDLE;
                    count_en   = 1'b1;
                end
            end
            S_HAZ_ON:  if (phase_end) state_next = S_HAZ_OFF;
            S_HAZ_OFF: if (phase_end) state_next = HAZARD ? S_HAZ_ON : S_IDLE;
            S_ERR: begin
                if (HAZARD)
                    state_next = S_HAZ_ON;
                else if (!LEFT || !RIGHT)
                    state_next = S_IDLE;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_reg  <= S_IDLE;
            tmr_reg    <= 24'd0;
            cycles_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                tmr_reg <= 24'd0;
            else if (timed)
                tmr_reg <= tmr_reg + 24'd1;
            if (count_en && (cycles_reg != 8'hFF))
                cycles_reg <= cycles_reg + 8'd1;
        end
    end

    // Each bank is a thermometer of lit lamps, filled from the inner lamp.
    always_comb begin
        l_level = 2'd0;
        r_level = 2'd0;
        case (state_reg)
            S_L1:     l_level = 2'd1;
            S_L2:     l_level = 2'd2;
            S_L3:     l_level = 2'd3;
            S_R1:     r_level = 2'd1;
            S_R2:     r_level = 2'd2;
            S_R3:     r_level = 2'd3;
            S_HAZ_ON: begin
                l_level = 2'd3;
                r_level = 2'd3;
            end
            default: begin
                l_level = 2'd0;
                r_level = 2'd0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lamp
            assign L_SIGNAL[gi]     = (l_level > 2'(gi));
            assign R_SIGNAL[2 - gi] = (r_level > 2'(gi));
        end
    endgenerate

    assign ERROR  = (state_reg != S_ERR);
    assign CYCLES = cycles_reg;

endmodule

// File: tb/tb_turn_signal_scheduler.sv
// Directed bench for turn_signal_scheduler: vector table on a STEP_DIV=4 instance,
// plus a CYCLES saturation run on a STEP_DIV=2 instance.
module tb_turn_signal_scheduler;

    typedef struct {
        logic       rst;
        logic       l;
        logic       r;
        logic       h;
        logic [2:0] el;
        logic [2:0] er;
        logic       ee;
        logic [7:0] ec;
    } vec_t;

    logic       clk;
    logic       rst, left_in, right_in, hazard_in;
    logic [2:0] l_sig, r_sig;
    logic       err_n;
    logic [7:0] cycles;

    logic       rst2, right2, zero2;
    logic [2:0] l_sig2, r_sig2;
    logic       err_n2;
    logic [7:0] cycles2;

    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    turn_signal_scheduler #(.STEP_DIV(4)) dut (
        .CLOCK(clk), .RESET(rst), .LEFT(left_in), .RIGHT(right_in), .HAZARD(hazard_in),
        .L_SIGNAL(l_sig), .R_SIGNAL(r_sig), .ERROR(err_n), .CYCLES(cycles)
    );

    turn_signal_scheduler #(.STEP_DIV(2)) dut2 (
        .CLOCK(clk), .RESET(rst2), .LEFT(zero2), .RIGHT(right2), .HAZARD(zero2),
        .L_SIGNAL(l_sig2), .R_SIGNAL(r_sig2), .ERROR(err_n2), .CYCLES(cycles2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst_v, input logic l, input logic r, input logic h,
                       input logic [2:0] el, input logic [2:0] er, input logic ee,
                       input logic [7:0] ec, input int n);
        vec_t v;
        v.rst = rst_v; v.l = l; v.r = r; v.h = h;
        v.el = el; v.er = er; v.ee = ee; v.ec = ec;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [14:0] act,
                         input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %0d: got L=%b R=%b ERR=%b CYC=%0d, required L=%b R=%b ERR=%b CYC=%0d",
                     name, idx, act[14:12], act[11:9], act[8], act[7:0],
                     exp[14:12], exp[11:9], exp[8], exp[7:0]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; left_in = 1'b0; right_in = 1'b0; hazard_in = 1'b0;
        rst2 = 1'b1; right2 = 1'b0; zero2 = 1'b0;

        // rst l r h  L R ERR CYC count
        add(1, 1, 0, 0, 3'b000, 3'b000, 1, 0, 2);
        // continuous LEFT, 26 cycles
        add(0, 1, 0, 0, 3'b001, 3'b000, 1, 0, 4);
        add(0, 1, 0, 0, 3'b011, 3'b000, 1, 0, 4);
        add(0, 1, 0, 0, 3'b111, 3'b000, 1, 0, 4);
        add(0, 1, 0, 0, 3'b000, 3'b000, 1, 1, 1);
        add(0, 1, 0, 0, 3'b001, 3'b000, 1, 1, 4);
        add(0, 1, 0, 0, 3'b011, 3'b000, 1, 1, 4);
        add(0, 1, 0, 0, 3'b111, 3'b000, 1, 1, 4);
        add(0, 1, 0, 0, 3'b000, 3'b000, 1, 2, 1);
        // RIGHT dropped mid-R2
        add(0, 0, 1, 0, 3'b000, 3'b100, 1, 2, 4);
        add(0, 0, 1, 0, 3'b000, 3'b110, 1, 2, 2);
        add(0, 0, 0, 0, 3'b000, 3'b110, 1, 2, 2);
        add(0, 0, 0, 0, 3'b000, 3'b000, 1, 2, 2);
        // conflict from IDLE, then drop RIGHT
        add(0, 1, 1, 0, 3'b000, 3'b000, 0, 2, 2);
        add(0, 1, 0, 0, 3'b000, 3'b000, 1, 2, 1);
        add(0, 1, 0, 0, 3'b001, 3'b000, 1, 2, 1);
        add(0, 0, 0, 0, 3'b001, 3'b000, 1, 2, 3);
        add(0, 0, 0, 0, 3'b000, 3'b000, 1, 2, 1);
        // HAZARD raised during R1, released before the pair completes
        add(0, 0, 1, 0, 3'b000, 3'b100, 1, 2, 2);
        add(0, 0, 0, 1, 3'b000, 3'b100, 1, 2, 2);
        add(0, 0, 0, 1, 3'b111, 3'b111, 1, 2, 1);
        add(0, 0, 0, 0, 3'b111, 3'b111, 1, 2, 3);
        add(0, 0, 0, 0, 3'b000, 3'b000, 1, 2, 5);
        add(0, 1, 0, 0, 3'b001, 3'b000, 1, 2, 1);
        add(0, 0, 0, 0, 3'b001, 3'b000, 1, 2, 3);
        add(0, 0, 0, 0, 3'b000, 3'b000, 1, 2, 1);
        // continuous HAZARD: no IDLE gap between pairs
        add(0, 0, 0, 1, 3'b111, 3'b111, 1, 2, 4);
        add(0, 0, 0, 1, 3'b000, 3'b000, 1, 2, 4);
        add(0, 0, 0, 1, 3'b111, 3'b111, 1, 2, 4);
        add(0, 0, 0, 0, 3'b000, 3'b000, 1, 2, 5);
        add(0, 1, 0, 0, 3'b001, 3'b000, 1, 2, 1);
        add(0, 0, 0, 0, 3'b001, 3'b000, 1, 2, 3);
        add(0, 0, 0, 0, 3'b000, 3'b000, 1, 2, 1);
        // L1 phase end with RIGHT only: switches to R1
        add(0, 1, 0, 0, 3'b001, 3'b000, 1, 2, 1);
        add(0, 0, 1, 0, 3'b001, 3'b000, 1, 2, 3);
        add(0, 0, 1, 0, 3'b000, 3'b100, 1, 2, 1);
        add(0, 0, 0, 0, 3'b000, 3'b100, 1, 2, 3);
        add(0, 0, 0, 0, 3'b000, 3'b000, 1, 2, 1);
        // L3 ends together with a new conflict: count, IDLE, then ERR
        add(0, 1, 0, 0, 3'b001, 3'b000, 1, 2, 4);
        add(0, 1, 0, 0, 3'b011, 3'b000, 1, 2, 4);
        add(0, 1, 0, 0, 3'b111, 3'b000, 1, 2, 3);
        add(0, 1, 1, 0, 3'b111, 3'b000, 1, 2, 1);
        add(0, 1, 1, 0, 3'b000, 3'b000, 1, 3, 1);
        add(0, 1, 1, 0, 3'b000, 3'b000, 0, 3, 1);
        add(0, 0, 0, 0, 3'b000, 3'b000, 1, 3, 1);
        // reset mid-sequence
        add(0, 1, 0, 0, 3'b001, 3'b000, 1, 3, 4);
        add(0, 1, 0, 0, 3'b011, 3'b000, 1, 3, 2);
        add(1, 1, 0, 0, 3'b000, 3'b000, 1, 0, 1);
        add(0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 1);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst; left_in = vecs[i].l;
            right_in = vecs[i].r; hazard_in = vecs[i].h;
            @(posedge clk);
            #1;
            check("vec", i, {l_sig, r_sig, err_n, cycles},
                  {vecs[i].el, vecs[i].er, vecs[i].ee, vecs[i].ec});
        end

        // saturation on the STEP_DIV=2 instance: one sequence every 7 edges
        rst2 = 1'b1; right2 = 1'b1;
        @(posedge clk);
        #1;
        check("sat_reset", 0, {l_sig2, r_sig2, err_n2, cycles2}, {3'b000, 3'b000, 1'b1, 8'd0});
        rst2 = 1'b0;
        for (int n = 1; n <= 260; n++) begin
            repeat (7) @(posedge clk);
            #1;
            check("sat_seq", n, {l_sig2, r_sig2, err_n2, cycles2},
                  {3'b000, 3'b000, 1'b1, (n > 255) ? 8'd255 : 8'(n)});
        end
        @(posedge clk);
        #1;
        check("sat_r1", 0, {l_sig2, r_sig2, err_n2, cycles2}, {3'b000, 3'b100, 1'b1, 8'd255});
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        check("sat_clear", 0, {l_sig2, r_sig2, err_n2, cycles2}, {3'b000, 3'b000, 1'b1, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
